// File: rtl/mag_cmp_pkg.sv
// rtl/mag_cmp_pkg.sv - shared types and helpers for the sequential magnitude comparator
package mag_cmp_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Encoded comparison verdict
  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_GT = 2'd1,
    CMP_LT = 2'd2
  } cmp_res_t;

  // Ceiling log2, used to size the slice index
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmp2_slice.sv
// rtl/cmp2_slice.sv - combinational 2-bit unsigned equal/greater/less slice comparator
module cmp2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq,
  output logic       gt,
  output logic       lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/mag_cmp_seq.sv
// rtl/mag_cmp_seq.sv - sequential N-bit magnitude comparator controller, optional MAG_CMP_SEQ_EARLY_EXIT_EN
module mag_cmp_seq
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Eq,
  output logic             Gt,
  output logic             Lt
);

  localparam int NS = WIDTH / 2;
  localparam int IW = (clog2(NS) < 1) ? 1 : clog2(NS);

  state_t         r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]  r_idx;
  logic           r_seen;
  cmp_res_t       r_verdict;

  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic           w_eq;
  logic           w_gt;
  logic           w_lt;
  logic           w_record;
  cmp_res_t       w_slice_res;
  cmp_res_t       w_verdict;
  logic           w_last;
  logic           w_exit;

  // Select the current 2-bit slice of each operand, MSB slice first
  assign w_a_sh = r_a >> {r_idx, 1'b0};
  assign w_b_sh = r_b >> {r_idx, 1'b0};

  cmp2_slice u_slice (
    .a  (w_a_sh[1:0]),
    .b  (w_b_sh[1:0]),
    .eq (w_eq),
    .gt (w_gt),
    .lt (w_lt)
  );

  // The first unequal slice decides; later slices never overwrite it
  assign w_record    = !r_seen && !w_eq;
  assign w_slice_res = w_gt ? CMP_GT : (w_lt ? CMP_LT : CMP_EQ);
  assign w_verdict   = w_record ? w_slice_res : r_verdict;
  assign w_last      = (r_idx == '0);

`ifdef MAG_CMP_SEQ_EARLY_EXIT_EN
  assign w_exit = w_last || w_record;
`else
  // Always walk every slice so timing does not depend on operand data
  assign w_exit = w_last;
`endif

  // Controller FSM with registered handshake and verdict outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      Eq        <= 1'b0;
      Gt        <= 1'b0;
      Lt        <= 1'b0;
      r_seen    <= 1'b0;
      r_verdict <= CMP_EQ;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a       <= A;
            r_b       <= B;
            r_idx     <= IW'(NS - 1);
            r_seen    <= 1'b0;
            r_verdict <= CMP_EQ;
            Eq        <= 1'b0;
            Gt        <= 1'b0;
            Lt        <= 1'b0;
            busy      <= 1'b1;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_verdict <= w_verdict;
          r_seen    <= r_seen || w_record;
          if (w_exit) begin
            Eq      <= (w_verdict == CMP_EQ);
            Gt      <= (w_verdict == CMP_GT);
            Lt      <= (w_verdict == CMP_LT);
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mag_cmp_seq.sv
// tb/tb_mag_cmp_seq.sv - directed self-checking bench for mag_cmp_seq
module tb_mag_cmp_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic       Eq;
  logic       Gt;
  logic       Lt;

  int passed;
  int total;
  int lat;
  int busy_cnt;
  int done_seen;

`ifdef MAG_CMP_SEQ_EARLY_EXIT_EN
  localparam int LAT_MSB = 2;
`else
  localparam int LAT_MSB = 5;
`endif

  mag_cmp_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Eq    (Eq),
    .Gt    (Gt),
    .Lt    (Lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one start, then wait (bounded) for done; checks latency and verdict
  task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int exp_lat, input logic [2:0] exp_egl);
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (busy) busy_cnt++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy_cnt"}, busy_cnt, exp_lat);
    check({tag, "_egl"}, {Eq, Gt, Lt}, exp_egl);
    tick();
    check({tag, "_after_busy_done"}, {busy, done}, 2'b00);
    check({tag, "_hold_egl"}, {Eq, Gt, Lt}, exp_egl);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    start  = 1'b1;
    A      = 8'hFF;
    B      = 8'h00;

    // Reset dominates start for two cycles
    tick();
    check("rst_c1", {busy, done, Eq, Gt, Lt}, 5'b0);
    tick();
    check("rst_c2", {busy, done, Eq, Gt, Lt}, 5'b0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("idle_after_rst", {busy, done}, 2'b00);

    // Equal operands walk all slices
    run_cmp("eq_a5", 8'hA5, 8'hA5, 5, 3'b100);

    // MSB slice decides
    run_cmp("gt_80_7f", 8'h80, 8'h7F, LAT_MSB, 3'b010);

    // Only the LSB slice differs
    run_cmp("lt_12_13", 8'h12, 8'h13, 5, 3'b001);
    run_cmp("gt_13_12", 8'h13, 8'h12, 5, 3'b010);

    // Starts while busy (cycles 1-3 and the DONE cycle) are ignored
    A = 8'h01;
    B = 8'h02;
    start = 1'b1;
    tick();
    A = 8'hFF;
    B = 8'h00;
    lat = 1;
    done_seen = 0;
    while (!done && lat < 20) begin
      start = (lat <= 3) ? 1'b1 : 1'b0;
      tick();
      lat++;
    end
    check("ign_lat", lat, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_after_done", {busy, done}, 2'b00);
    check("ign_egl", {Eq, Gt, Lt}, 3'b001);
    tick();
    check("ign_no_restart", busy, 1'b0);
    run_cmp("after_ign_ff_00", 8'hFF, 8'h00, LAT_MSB, 3'b010);

    // Reset in the middle of RUN aborts with no partial result
    A = 8'h40;
    B = 8'h40;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", {busy, done, Eq, Gt, Lt}, 5'b0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_cmp("after_abort_03_02", 8'h03, 8'h02, 5, 3'b010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mag_cmp_seq.md
Name: mag_cmp_seq

Overview:
Sequential N-bit unsigned magnitude comparator controller. It feeds the 2-bit equal/greater/less slice comparator one operand pair at a time, MSB slice first, and accumulates the final Eq/Gt/Lt verdict. It sits between a requesting datapath and a single shared 2-bit comparator slice, and uses a start/busy/done handshake.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2; number of slices NS = WIDTH/2.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a comparison; sampled only in IDLE
A  input  WIDTH  operand A (unsigned), captured when start is accepted
B  input  WIDTH  operand B (unsigned), captured when start is accepted
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when the result becomes valid
Eq  output  1  A == B
Gt  output  1  A > B
Lt  output  1  A < B

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on the rising edge with rst=1: state=IDLE, busy=0, done=0, Eq=Gt=Lt=0. Operand registers and the slice index are don't-care. rst overrides start and any in-flight operation, including mid-RUN, with no partial result emitted.
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch A and B, set idx=NS-1, clear Eq/Gt/Lt, and go to RUN. Otherwise stay in IDLE.
- RUN: in each cycle, the slice comparator evaluates A[2*idx+1:2*idx] against B[2*idx+1:2*idx].
  - Slice Gt or Lt, with no verdict yet: record the verdict in a sticky flag.
  - Exit rule with EARLY_EXIT_EN: see Optional Feature.
  - idx==0 (last slice): go to DONE. If no unequal slice was seen, the verdict is Eq.
  - Otherwise: idx decrements by 1.
- DONE: done=1 for exactly one cycle. Eq/Gt/Lt are registered on entry to DONE, are mutually exclusive, and exactly one is high. Next state is IDLE.
- Results hold after DONE until the next accepted start, which clears them.
- start while busy=1, including in the DONE cycle: ignored, no queuing.
- Latency from the start-accept edge to the done cycle: NS+1 cycles worst case. For WIDTH=8 that is done high in cycle 5 after the start edge.
- Only the first unequal slice (the MSB-most one) determines Gt/Lt. Later slices never overwrite a recorded verdict.

Optional Feature:
Macro: MAG_CMP_SEQ_EARLY_EXIT_EN.
- Defined: RUN exits to DONE in the same cycle that the first unequal slice is seen. Latency varies from 2 to NS+1 cycles.
- Undefined: RUN always walks all NS slices, so latency is a constant NS+1 regardless of data. This gives data-independent timing. The verdict is identical either way.

Decomposition:
- Shared package mag_cmp_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - 2-bit result encoding {CMP_EQ, CMP_GT, CMP_LT};
  - function clog2 for the idx width.
- One natural sub-module, cmp2_slice. It is purely combinational: inputs a[1:0] and b[1:0], outputs eq, gt, lt, using the same function as the existing 2-bit comparator. It is instantiated once and driven by the controller's idx multiplexer.
- The controller holds the FSM, the operand registers, idx, and the sticky verdict.

Test Plan:
1. Hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, Eq=Gt=Lt=0 throughout and no transition to RUN.
2. WIDTH=8, A=0xA5, B=0xA5, start for 1 cycle -> busy for 5 cycles; done pulses in cycle 5; then Eq=1, Gt=0, Lt=0.
3. A=0x80, B=0x7F -> Gt=1. With the macro defined, done in cycle 2. Without it, done in cycle 5.
4. A=0x12, B=0x13 (only the LSB slice differs) -> Lt=1 and done in cycle 5 in both builds. Also check with A=0x13, B=0x12 -> Gt=1.
5. Start A=0x01, B=0x02, then reassert start with A=0xFF, B=0x00 on cycles 1-3 and on the DONE cycle -> all ignored; the result is Lt=1. The next start accepted in IDLE yields Gt=1.
6. Assert rst for 1 cycle during RUN (A=0x40, B=0x40, cycle 2) -> the next cycle has busy=0, no done pulse, Eq=Gt=Lt=0. A new start with A=0x03, B=0x02 completes with Gt=1.
